ea_sequencer: RTL and testbench

Multi-cycle effective-address controller for the LC-3b datapath. It accepts one instruction word plus incremented PC, selects and sign-extends the instruction's offset field, and shifts it by 1 for word/PC-relative forms. When the base is a register, it reads that register through a one-port register-file handshake, then adds base and offset. It sits between decode and the memory/branch units and is the single owner of offset sign-extension for address formation.

---
 rtl/ea_sequencer_if.sv | 26 ++
 rtl/ea_sequencer.sv | 126 ++++++++++++
 tb/tb_ea_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ea_sequencer_if.sv
// Request, register-file and result signals of the LC-3b effective-address sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding datapath.
interface ea_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] ir;
  logic [15:0] pc;
  logic        rf_rd_en;
  logic [2:0]  rf_addr;
  logic [15:0] rf_data;
  logic        ea_valid;
  logic        ea_ready;
  logic [15:0] ea;
  logic        ea_err;
  logic        busy;

  modport slave (
    input  req_valid, ir, pc, rf_data, ea_ready,
    output req_ready, rf_rd_en, rf_addr, ea_valid, ea, ea_err, busy
  );

  modport master (
    output req_valid, ir, pc, rf_data, ea_ready,
    input  req_ready, rf_rd_en, rf_addr, ea_valid, ea, ea_err, busy
  );
endinterface

// File: rtl/ea_sequencer.sv
// Multi-cycle LC-3b effective-address controller: decodes the offset field,
// fetches a base register when needed and adds base and offset modulo 2^16.
module ea_sequencer (
  input  logic           clk,
  input  logic           reset,
  ea_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, DECODE, READ, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] base_q, base_d;
  logic [15:0] off_q, off_d;
  logic [15:0] ea_q, ea_d;
  logic        err_q, err_d;
  logic        rd_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= 16'h0000;
      pc_q    <= 16'h0000;
      base_q  <= 16'h0000;
      off_q   <= 16'h0000;
      ea_q    <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      base_q  <= base_d;
      off_q   <= off_d;
      ea_q    <= ea_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    base_d  = base_q;
    off_d   = off_q;
    ea_d    = ea_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          ir_d    = bus.ir;
          pc_d    = bus.pc;
          ea_d    = 16'h0000;
          err_d   = 1'b0;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // Offsets are extended first, then shifted, so bit 0 of a shifted offset is always 0
        case (ir_q[15:12])
          4'b0000, 4'b1110: begin
            base_d  = pc_q;
            off_d   = {{6{ir_q[8]}}, ir_q[8:0], 1'b0};
            state_d = CALC;
          end
          4'b0100: begin
            if (ir_q[11]) begin
              base_d  = pc_q;
              off_d   = {{4{ir_q[10]}}, ir_q[10:0], 1'b0};
              state_d = CALC;
            end else begin
              off_d   = 16'h0000;
              rd_en   = 1'b1;
              state_d = READ;
            end
          end
          4'b1100: begin
            off_d   = 16'h0000;
            rd_en   = 1'b1;
            state_d = READ;
          end
          4'b0010, 4'b0011: begin
            off_d   = {{10{ir_q[5]}}, ir_q[5:0]};
            rd_en   = 1'b1;
            state_d = READ;
          end
          4'b0110, 4'b0111: begin
            off_d   = {{9{ir_q[5]}}, ir_q[5:0], 1'b0};
            rd_en   = 1'b1;
            state_d = READ;
          end
          default: begin
            err_d   = 1'b1;
            ea_d    = 16'h0000;
            state_d = DONE;
          end
        endcase
      end
      READ: begin
        base_d  = bus.rf_data;
        state_d = CALC;
      end
      CALC: begin
        ea_d    = base_q + off_q;
        state_d = DONE;
      end
      DONE: begin
        if (bus.ea_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with reset keeps the handshake quiet while the block is being cleared
  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign bus.rf_rd_en  = rd_en && !reset;
  assign bus.rf_addr   = ir_q[8:6];
  assign bus.ea_valid  = (state_q == DONE);
  assign bus.ea        = ea_q;
  assign bus.ea_err    = err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ea_sequencer.sv
// Directed-vector bench for ea_sequencer with a small register-file responder
// and hand-computed expected addresses and latencies.
module tb_ea_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [15:0] regs [8];

  ea_sequencer_if bus ();

  ea_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file answers one cycle after the read strobe; otherwise drives a marker value
  always @(posedge clk) begin
    bus.rf_data <= bus.rf_rd_en ? regs[bus.rf_addr] : 16'hDEAD;
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [15:0] ir, input logic [15:0] pc,
                               input logic [15:0] exp_ea, input logic exp_err,
                               input int exp_lat, input int exp_rd, input logic [2:0] exp_addr);
    int lat;
    int rd_count;
    lat = 0;
    rd_count = 0;
    @(negedge clk);
    checkOutput({tag, "_ready"}, 16'(bus.req_ready), 16'h1);
    bus.req_valid = 1'b1;
    bus.ir        = ir;
    bus.pc        = pc;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.ir        = 16'h1000;
    bus.pc        = 16'hFFFF;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.rf_rd_en) begin
        rd_count++;
        checkOutput({tag, "_rfaddr"}, 16'(bus.rf_addr), 16'(exp_addr));
      end
      if (bus.ea_valid) begin
        lat = n;
        break;
      end
    end
    checkOutput({tag, "_lat"}, 16'(lat), 16'(exp_lat));
    checkOutput({tag, "_rdcnt"}, 16'(rd_count), 16'(exp_rd));
    checkOutput({tag, "_ea"}, bus.ea, exp_ea);
    checkOutput({tag, "_err"}, 16'(bus.ea_err), 16'(exp_err));
    if (lat == 0) begin
      $display("[TB] %s gave up waiting for ea_valid", tag);
      return;
    end
    bus.ea_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.ea_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_vld_drop"}, 16'(bus.ea_valid), 16'h0);
    checkOutput({tag, "_ready_back"}, 16'(bus.req_ready), 16'h1);
  endtask

  initial begin
    int seen;
    total = 0;
    bad   = 0;
    regs[0] = 16'h0000; regs[1] = 16'h0100; regs[2] = 16'h4000; regs[3] = 16'h0000;
    regs[4] = 16'h0000; regs[5] = 16'h0000; regs[6] = 16'h0000; regs[7] = 16'h1234;
    reset        = 1'b1;
    bus.req_valid = 1'b1;
    bus.ir        = 16'hE1FF;
    bus.pc        = 16'h3000;
    bus.ea_ready  = 1'b0;

    // Request during reset must not be accepted
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 16'(bus.req_ready), 16'h0);
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", 16'(bus.busy), 16'h0);
    checkOutput("rst_valid", 16'(bus.ea_valid), 16'h0);
    checkOutput("rst_ea", bus.ea, 16'h0000);
    checkOutput("rst_err", 16'(bus.ea_err), 16'h0);
    checkOutput("rst_rfaddr", 16'(bus.rf_addr), 16'h0);
    checkOutput("rst_rden", 16'(bus.rf_rd_en), 16'h0);
    checkOutput("rst_ready1", 16'(bus.req_ready), 16'h1);

    applyStimulus("lea",  16'hE1FF, 16'h3000, 16'h2FFE, 1'b0, 3, 0, 3'd0);
    applyStimulus("br",   16'h0E05, 16'h3002, 16'h300C, 1'b0, 3, 0, 3'd0);
    applyStimulus("jsr",  16'h4FFF, 16'h0000, 16'hFFFE, 1'b0, 3, 0, 3'd0);
    applyStimulus("add",  16'h1000, 16'h1234, 16'h0000, 1'b1, 2, 0, 3'd0);
    applyStimulus("ldw",  16'h62BF, 16'h5555, 16'h3FFE, 1'b0, 4, 1, 3'd2);
    applyStimulus("ldb",  16'h22BF, 16'h5555, 16'h3FFF, 1'b0, 4, 1, 3'd2);
    applyStimulus("jmp",  16'hC1C0, 16'h5555, 16'h1234, 1'b0, 4, 1, 3'd7);
    applyStimulus("jsrr", 16'h4080, 16'h5555, 16'h4000, 1'b0, 4, 1, 3'd2);
    applyStimulus("ldwp", 16'h6045, 16'h5555, 16'h010A, 1'b0, 4, 1, 3'd1);

    // Backpressure: DONE held with ea_ready low while req_valid/ir toggle
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.ir        = 16'hE1FF;
    bus.pc        = 16'h3000;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      bus.req_valid = i[0];
      bus.ir        = 16'h6000 + 16'(i);
      @(negedge clk);
      checkOutput("bp_valid", 16'(bus.ea_valid), 16'h1);
      checkOutput("bp_ea", bus.ea, 16'h2FFE);
      checkOutput("bp_ready", 16'(bus.req_ready), 16'h0);
      @(posedge clk);
    end
    #1;
    bus.req_valid = 1'b0;
    bus.ea_ready  = 1'b1;
    @(posedge clk);
    #1;
    bus.ea_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_release_ready", 16'(bus.req_ready), 16'h1);
    checkOutput("bp_release_valid", 16'(bus.ea_valid), 16'h0);

    // Reset while the LDW is in READ drops the request
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.ir        = 16'h62BF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_busy", 16'(bus.busy), 16'h1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_busy0", 16'(bus.busy), 16'h0);
    checkOutput("mid_valid0", 16'(bus.ea_valid), 16'h0);
    checkOutput("mid_ea0", bus.ea, 16'h0000);
    checkOutput("mid_err0", 16'(bus.ea_err), 16'h0);
    checkOutput("mid_rfaddr0", 16'(bus.rf_addr), 16'h0);
    checkOutput("mid_rden0", 16'(bus.rf_rd_en), 16'h0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.ea_valid) seen++;
    end
    checkOutput("mid_no_valid", 16'(seen), 16'h0);
    applyStimulus("lea2", 16'hE1FF, 16'h3000, 16'h2FFE, 1'b0, 3, 0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
